// File: rtl/mem_stage.sv
// mem_stage -- memory-access stage of the 5-stage pipeline.
//
// Takes the EX/MEM register outputs and issues LW/SW to data memory over a
// registered req/ack handshake. It stalls upstream while an access is in
// flight and registers the write-back payload into the MEM/WB boundary.
//
// Optional build macro: MEM_TIMEOUT_EN. When it is defined, an access that
// sees no ack for TIMEOUT_CYC REQ cycles is aborted, err_o sets (sticky) and
// the instruction retires without writing the register file. When it is not
// defined, REQ waits indefinitely and err_o is 0.
//
// Ports
//   clk, rst_n        pipeline clock, asynchronous active-low reset
//   mem_addr_i        effective address          alu_data_i  ALU result / store data
//   pc_next_i         PC+2 (PCS write-back)      rd_i, op_i  destination, opcode
//   flush_i           kill the current instruction (taken branch)
//   dmem_req/we/addr/wdata  registered memory request
//   dmem_rdata, dmem_ack    load data and one-cycle completion pulse
//   stall_o           hold upstream stages (EX/MEM enable = ~stall_o)
//   wb_data_o, wb_rd_o, wb_en_o, hlt_o  registered MEM/WB payload
//   err_o             sticky access-timeout flag
module mem_stage #(
   parameter int unsigned TIMEOUT_CYC = 255
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [15:0] mem_addr_i,
   input  logic [15:0] alu_data_i,
   input  logic [15:0] pc_next_i,
   input  logic [3:0]  rd_i,
   input  logic [3:0]  op_i,
   input  logic        flush_i,
   output logic        dmem_req,
   output logic        dmem_we,
   output logic [15:0] dmem_addr,
   output logic [15:0] dmem_wdata,
   input  logic [15:0] dmem_rdata,
   input  logic        dmem_ack,
   output logic        stall_o,
   output logic [15:0] wb_data_o,
   output logic [3:0]  wb_rd_o,
   output logic        wb_en_o,
   output logic        hlt_o,
   output logic        err_o
);

   localparam logic [3:0] OP_LW  = 4'b1000;
   localparam logic [3:0] OP_SW  = 4'b1001;
   localparam logic [3:0] OP_LHB = 4'b1010;
   localparam logic [3:0] OP_LLB = 4'b1011;
   localparam logic [3:0] OP_PCS = 4'b1110;
   localparam logic [3:0] OP_HLT = 4'b1111;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t      state_q, state_d;
   logic        req_q, req_d;
   logic        we_q, we_d;
   logic [15:0] addr_q, addr_d;
   logic [15:0] wdata_q, wdata_d;
   logic [15:0] lbuf_q, lbuf_d;
   logic [15:0] wb_data_q, wb_data_d;
   logic [3:0]  wb_rd_q, wb_rd_d;
   logic        wb_en_q, wb_en_d;
   logic        hlt_q, hlt_d;

   logic is_mem;
   logic op_wr;

`ifdef MEM_TIMEOUT_EN
   localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYC - 1);
   logic [7:0] cnt_q, cnt_d;
   logic       err_q, err_d;
   logic       to_q, to_d;    // current access was aborted
   logic       to_hit;
`endif

   always_comb begin
      is_mem = (op_i == OP_LW) || (op_i == OP_SW);
      op_wr  = ~op_i[3] || (op_i == OP_LW) || (op_i == OP_LHB) ||
               (op_i == OP_LLB) || (op_i == OP_PCS);
   end

`ifdef MEM_TIMEOUT_EN
   // Ack on the final allowed cycle wins over the abort.
   always_comb to_hit = (cnt_q == TO_LAST) && !dmem_ack;
`endif

   always_comb begin
      state_d   = state_q;
      req_d     = req_q;
      we_d      = we_q;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      lbuf_d    = lbuf_q;
      wb_data_d = wb_data_q;
      wb_rd_d   = wb_rd_q;
      wb_en_d   = wb_en_q;
      hlt_d     = hlt_q;
`ifdef MEM_TIMEOUT_EN
      cnt_d     = cnt_q;
      err_d     = err_q;
      to_d      = to_q;
`endif
      case (state_q)
         S_IDLE: begin
            // Non-memory ops retire here every cycle; a memory op entering
            // REQ leaves a bubble behind it until it completes in DONE.
            wb_rd_d   = rd_i;
            wb_data_d = (op_i == OP_PCS) ? pc_next_i : alu_data_i;
            wb_en_d   = op_wr && (rd_i != 4'd0) && !flush_i && !is_mem;
            hlt_d     = (op_i == OP_HLT) && !flush_i;
            if (is_mem && !flush_i) begin
               state_d = S_REQ;
               req_d   = 1'b1;
               we_d    = (op_i == OP_SW);
               addr_d  = mem_addr_i;
               wdata_d = alu_data_i;
`ifdef MEM_TIMEOUT_EN
               cnt_d   = 8'd0;
               to_d    = 1'b0;
`endif
            end
         end
         S_REQ: begin
            if (dmem_ack) begin
               lbuf_d  = dmem_rdata;
               req_d   = 1'b0;
               state_d = S_DONE;
            end
`ifdef MEM_TIMEOUT_EN
            else if (to_hit) begin
               req_d   = 1'b0;
               to_d    = 1'b1;
               err_d   = 1'b1;
               state_d = S_DONE;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
`endif
         end
         S_DONE: begin
            // EX/MEM is still holding the memory op here.
            wb_rd_d   = rd_i;
            wb_data_d = (op_i == OP_LW) ? lbuf_q : alu_data_i;
            wb_en_d   = op_wr && (rd_i != 4'd0)
`ifdef MEM_TIMEOUT_EN
                        && !to_q
`endif
                        ;
            hlt_d     = 1'b0;
            state_d   = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         req_q     <= 1'b0;
         we_q      <= 1'b0;
         addr_q    <= 16'd0;
         wdata_q   <= 16'd0;
         lbuf_q    <= 16'd0;
         wb_data_q <= 16'd0;
         wb_rd_q   <= 4'd0;
         wb_en_q   <= 1'b0;
         hlt_q     <= 1'b0;
`ifdef MEM_TIMEOUT_EN
         cnt_q     <= 8'd0;
         err_q     <= 1'b0;
         to_q      <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         req_q     <= req_d;
         we_q      <= we_d;
         addr_q    <= addr_d;
         wdata_q   <= wdata_d;
         lbuf_q    <= lbuf_d;
         wb_data_q <= wb_data_d;
         wb_rd_q   <= wb_rd_d;
         wb_en_q   <= wb_en_d;
         hlt_q     <= hlt_d;
`ifdef MEM_TIMEOUT_EN
         cnt_q     <= cnt_d;
         err_q     <= err_d;
         to_q      <= to_d;
`endif
      end
   end

   // Gated by rst_n so upstream is released the moment reset asserts,
   // even though EX/MEM may still be presenting the abandoned memory op.
   assign stall_o    = rst_n && is_mem && (state_q != S_DONE) && !flush_i;
   assign dmem_req   = req_q;
   assign dmem_we    = we_q;
   assign dmem_addr  = addr_q;
   assign dmem_wdata = wdata_q;
   assign wb_data_o  = wb_data_q;
   assign wb_rd_o    = wb_rd_q;
   assign wb_en_o    = wb_en_q;
   assign hlt_o      = hlt_q;
`ifdef MEM_TIMEOUT_EN
   assign err_o      = err_q;
`else
   assign err_o      = 1'b0;
`endif

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage -- self-checking bench for mem_stage. A memory responder with
// programmable ack latency serves requests; expectations come from an
// opcode-class table and a separate reference copy of memory.
module tb_mem_stage;

`ifdef MEM_TIMEOUT_EN
   localparam int TO = 4;
`else
   localparam int TO = 255;
`endif

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [15:0] mem_addr_i = '0, alu_data_i = '0, pc_next_i = '0;
   logic [3:0]  rd_i = '0, op_i = '0;
   logic        flush_i = 1'b0;
   logic        dmem_req, dmem_we;
   logic [15:0] dmem_addr, dmem_wdata;
   logic [15:0] dmem_rdata = '0;
   logic        dmem_ack;
   logic        ack_resp = 1'b0, ack_stray = 1'b0;
   logic        stall_o;
   logic [15:0] wb_data_o;
   logic [3:0]  wb_rd_o;
   logic        wb_en_o, hlt_o, err_o;

   assign dmem_ack = ack_resp | ack_stray;

   mem_stage #(.TIMEOUT_CYC(TO)) dut (
      .clk(clk), .rst_n(rst_n), .mem_addr_i(mem_addr_i), .alu_data_i(alu_data_i),
      .pc_next_i(pc_next_i), .rd_i(rd_i), .op_i(op_i), .flush_i(flush_i),
      .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
      .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack),
      .stall_o(stall_o), .wb_data_o(wb_data_o), .wb_rd_o(wb_rd_o),
      .wb_en_o(wb_en_o), .hlt_o(hlt_o), .err_o(err_o)
   );

   always #5 clk = ~clk;

   int   n_chk = 0, n_fail = 0;
   int   lat = 1;
   bit   ack_en = 1'b1;
   logic [15:0] mem     [0:255];
   logic [15:0] ref_mem [0:255];

   // Memory responder: pulses ack on the lat-th cycle that dmem_req is seen.
   initial begin
      int w;
      w = 0;
      forever begin
         @(posedge clk); #1;
         ack_resp = 1'b0;
         if (dmem_req && ack_en) begin
            w++;
            if (w >= lat) begin
               if (dmem_we) mem[dmem_addr[7:0]] = dmem_wdata;
               dmem_rdata = mem[dmem_addr[7:0]];
               ack_resp = 1'b1;
               w = 0;
            end
         end else begin
            w = 0;
         end
      end
   end

   // Spec-level opcode classes.
   function automatic bit ref_wr(input logic [3:0] op);
      if (op <= 4'd7) return 1'b1;
      return op inside {4'b1000, 4'b1010, 4'b1011, 4'b1110};
   endfunction

   task automatic do_reset();
      op_i = 4'd0; flush_i = 1'b0; rd_i = 4'd0;
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
   endtask

   // Presents one instruction (called at posedge+1) and returns at posedge+1
   // after the edge on which it retires.
   task automatic run_instr(input logic [3:0] op, input logic [3:0] rd,
                            input logic [15:0] alu, input logic [15:0] pc,
                            input logic [15:0] addr, input logic fl,
                            output int st, output logic we_seen);
      op_i = op; rd_i = rd; alu_data_i = alu; pc_next_i = pc;
      mem_addr_i = addr; flush_i = fl;
      st = 0; we_seen = 1'bx;
      #1;
      while (stall_o) begin
         st++;
         @(posedge clk); #2;
         if (dmem_req) we_seen = dmem_we;
         if (st > 600) break;
      end
      @(posedge clk); #1;
   endtask

   task automatic test_reset();
      do_reset();
      n_chk++;
      if ({dmem_req, dmem_we, stall_o, wb_en_o, hlt_o, err_o} !== 6'b0) begin
         n_fail++;
         $display("FAIL reset_ctl: got %b want 000000",
                  {dmem_req, dmem_we, stall_o, wb_en_o, hlt_o, err_o});
      end
      n_chk++;
      if ({dmem_addr, dmem_wdata, wb_data_o, wb_rd_o} !== 52'd0) begin
         n_fail++;
         $display("FAIL reset_data: addr %h wdata %h wb %h rd %h want 0",
                  dmem_addr, dmem_wdata, wb_data_o, wb_rd_o);
      end
   endtask

   task automatic test_alu();
      int st; logic we;
      run_instr(4'b0000, 4'd3, 16'h1234, 16'h0, 16'h0, 1'b0, st, we);
      n_chk++;
      if (st !== 0) begin n_fail++; $display("FAIL alu_stall: got %0d want 0", st); end
      n_chk++;
      if ({wb_data_o, wb_rd_o, wb_en_o} !== {16'h1234, 4'd3, 1'b1}) begin
         n_fail++;
         $display("FAIL alu_wb: got %h/%h/%b want 1234/3/1", wb_data_o, wb_rd_o, wb_en_o);
      end
   endtask

   task automatic test_lw();
      int st; logic we;
      mem[8'h40] = 16'hBEEF; ref_mem[8'h40] = 16'hBEEF;
      lat = 2;
      run_instr(4'b1000, 4'd7, 16'h0, 16'h0, 16'h0040, 1'b0, st, we);
      lat = 1;
      n_chk++;
      if (st !== 3) begin n_fail++; $display("FAIL lw_stall: got %0d want 3", st); end
      n_chk++;
      if ({wb_data_o, wb_rd_o, wb_en_o} !== {16'hBEEF, 4'd7, 1'b1}) begin
         n_fail++;
         $display("FAIL lw_wb: got %h/%h/%b want beef/7/1", wb_data_o, wb_rd_o, wb_en_o);
      end
   endtask

   task automatic test_sw_lw();
      int st; logic we;
      run_instr(4'b1001, 4'd2, 16'h00AA, 16'h0, 16'h0010, 1'b0, st, we);
      ref_mem[8'h10] = 16'h00AA;
      n_chk++;
      if (we !== 1'b1 || st !== 2) begin
         n_fail++; $display("FAIL sw_access: we %b stall %0d want 1 2", we, st);
      end
      n_chk++;
      if (wb_en_o !== 1'b0) begin n_fail++; $display("FAIL sw_wben: got %b want 0", wb_en_o); end
      n_chk++;
      if (dmem_req !== 1'b0) begin n_fail++; $display("FAIL sw_req_gap: got %b want 0", dmem_req); end
      run_instr(4'b1000, 4'd9, 16'h0, 16'h0, 16'h0010, 1'b0, st, we);
      n_chk++;
      if (we !== 1'b0 || st !== 2) begin
         n_fail++; $display("FAIL lw2_access: we %b stall %0d want 0 2", we, st);
      end
      n_chk++;
      if ({wb_data_o, wb_en_o} !== {16'h00AA, 1'b1}) begin
         n_fail++; $display("FAIL lw2_wb: got %h/%b want 00aa/1", wb_data_o, wb_en_o);
      end
   endtask

   task automatic test_misc();
      int st; logic we;
      run_instr(4'b1110, 4'd0, 16'h5555, 16'h0102, 16'h0, 1'b0, st, we);
      n_chk++;
      if (wb_en_o !== 1'b0) begin n_fail++; $display("FAIL pcs_rd0: wb_en %b want 0", wb_en_o); end
      run_instr(4'b1110, 4'd5, 16'h5555, 16'h0102, 16'h0, 1'b0, st, we);
      n_chk++;
      if ({wb_data_o, wb_en_o} !== {16'h0102, 1'b1}) begin
         n_fail++; $display("FAIL pcs_wb: got %h/%b want 0102/1", wb_data_o, wb_en_o);
      end
      run_instr(4'b1111, 4'd0, 16'h0, 16'h0, 16'h0, 1'b0, st, we);
      n_chk++;
      if ({hlt_o, wb_en_o} !== 2'b10) begin
         n_fail++; $display("FAIL hlt: hlt %b wb_en %b want 1 0", hlt_o, wb_en_o);
      end
      run_instr(4'b0001, 4'd4, 16'h7777, 16'h0, 16'h0, 1'b1, st, we);
      n_chk++;
      if ({hlt_o, wb_en_o} !== 2'b00) begin
         n_fail++; $display("FAIL flush_alu: hlt %b wb_en %b want 0 0", hlt_o, wb_en_o);
      end
      run_instr(4'b1000, 4'd4, 16'h0, 16'h0, 16'h0022, 1'b1, st, we);
      n_chk++;
      if (st !== 0 || dmem_req !== 1'b0 || wb_en_o !== 1'b0) begin
         n_fail++; $display("FAIL flush_lw: stall %0d req %b wb_en %b want 0 0 0", st, dmem_req, wb_en_o);
      end
   endtask

   task automatic test_random();
      int st, exp_st; logic we;
      logic [3:0] op, rd; logic [15:0] alu, pc, addr, exp_d; logic fl, exp_en, exp_h;
      for (int i = 0; i < 60; i++) begin
         op = 4'($urandom_range(0, 15));
         if ($urandom_range(0, 2) == 0) op = 4'($urandom_range(8, 9));
         rd = 4'($urandom_range(0, 15));
         alu = 16'($urandom); pc = 16'($urandom); addr = 16'($urandom);
         fl = ($urandom_range(0, 7) == 0);
         lat = $urandom_range(1, 3);
         exp_en = !fl && ref_wr(op) && rd != 4'd0;
         exp_h  = !fl && op == 4'b1111;
         exp_d  = (op == 4'b1000) ? ref_mem[addr[7:0]] : (op == 4'b1110) ? pc : alu;
         exp_st = (op inside {4'b1000, 4'b1001} && !fl) ? lat + 1 : 0;
         if (op == 4'b1001 && !fl) ref_mem[addr[7:0]] = alu;
         run_instr(op, rd, alu, pc, addr, fl, st, we);
         n_chk++;
         if (st !== exp_st) begin
            n_fail++; $display("FAIL rnd%0d_stall op %h: got %0d want %0d", i, op, st, exp_st);
         end
         n_chk++;
         if ({wb_en_o, hlt_o} !== {exp_en, exp_h}) begin
            n_fail++; $display("FAIL rnd%0d_ctl op %h: got %b%b want %b%b", i, op, wb_en_o, hlt_o, exp_en, exp_h);
         end
         if (exp_en) begin
            n_chk++;
            if ({wb_data_o, wb_rd_o} !== {exp_d, rd}) begin
               n_fail++; $display("FAIL rnd%0d_data op %h: got %h/%h want %h/%h", i, op, wb_data_o, wb_rd_o, exp_d, rd);
            end
         end
      end
      lat = 1;
   endtask

   task automatic test_reset_midreq();
      int st; logic we;
      ack_en = 1'b0;
      op_i = 4'b1000; rd_i = 4'd6; mem_addr_i = 16'h0030; flush_i = 1'b0;
      repeat (2) begin @(posedge clk); #1; end
      n_chk++;
      if (dmem_req !== 1'b1) begin n_fail++; $display("FAIL midreq_pre: req %b want 1", dmem_req); end
      #2 rst_n = 1'b0;
      #1;
      n_chk++;
      if ({dmem_req, stall_o} !== 2'b00) begin
         n_fail++; $display("FAIL midreq_async: req %b stall %b want 0 0", dmem_req, stall_o);
      end
      op_i = 4'b0000;
      @(posedge clk); #1 rst_n = 1'b1;
      ack_en = 1'b1;
      ack_stray = 1'b1;
      @(posedge clk); #1 ack_stray = 1'b0;
      n_chk++;
      if ({dmem_req, stall_o} !== 2'b00) begin
         n_fail++; $display("FAIL stray_ack: req %b stall %b want 0 0", dmem_req, stall_o);
      end
      ref_mem[8'h30] = 16'hC0DE; mem[8'h30] = 16'hC0DE;
      run_instr(4'b1000, 4'd6, 16'h0, 16'h0, 16'h0030, 1'b0, st, we);
      n_chk++;
      if (st !== 2 || {wb_data_o, wb_en_o} !== {16'hC0DE, 1'b1}) begin
         n_fail++; $display("FAIL post_reset_lw: stall %0d wb %h/%b want 2 c0de/1", st, wb_data_o, wb_en_o);
      end
   endtask

   task automatic test_timeout();
      int st; logic we;
`ifdef MEM_TIMEOUT_EN
      ack_en = 1'b0;
      run_instr(4'b1000, 4'd2, 16'h0, 16'h0, 16'h0050, 1'b0, st, we);
      ack_en = 1'b1;
      n_chk++;
      if (st !== 5 || err_o !== 1'b1 || wb_en_o !== 1'b0) begin
         n_fail++; $display("FAIL timeout: stall %0d err %b wb_en %b want 5 1 0", st, err_o, wb_en_o);
      end
      run_instr(4'b0010, 4'd1, 16'h4321, 16'h0, 16'h0, 1'b0, st, we);
      n_chk++;
      if (st !== 0 || {wb_data_o, wb_en_o, err_o} !== {16'h4321, 1'b1, 1'b1}) begin
         n_fail++; $display("FAIL timeout_resume: stall %0d wb %h/%b err %b want 0 4321/1 1", st, wb_data_o, wb_en_o, err_o);
      end
      do_reset();
      n_chk++;
      if (err_o !== 1'b0) begin n_fail++; $display("FAIL err_clear: got %b want 0", err_o); end
      mem[8'h50] = 16'h0F0F; ref_mem[8'h50] = 16'h0F0F;
      lat = 4;
      run_instr(4'b1000, 4'd2, 16'h0, 16'h0, 16'h0050, 1'b0, st, we);
      lat = 1;
      n_chk++;
      if (st !== 5 || err_o !== 1'b0 || {wb_data_o, wb_en_o} !== {16'h0F0F, 1'b1}) begin
         n_fail++; $display("FAIL ack_at_limit: stall %0d err %b wb %h/%b want 5 0 0f0f/1", st, err_o, wb_data_o, wb_en_o);
      end
`else
      lat = 9;
      run_instr(4'b1000, 4'd2, 16'h0, 16'h0, 16'h0050, 1'b0, st, we);
      lat = 1;
      n_chk++;
      if (st !== 10 || err_o !== 1'b0 || {wb_data_o, wb_en_o} !== {ref_mem[8'h50], 1'b1}) begin
         n_fail++; $display("FAIL long_wait: stall %0d err %b wb %h/%b want 10 0 %h/1", st, err_o, wb_data_o, wb_en_o, ref_mem[8'h50]);
      end
`endif
   endtask

   initial begin
      for (int i = 0; i < 256; i++) begin
         mem[i] = 16'($urandom);
         ref_mem[i] = mem[i];
      end
      test_reset();
      test_alu();
      test_lw();
      test_sw_lw();
      test_misc();
      test_random();
      test_reset_midreq();
      test_timeout();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, %0d failures so far", n_fail);
      $fatal(1);
   end

endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-access stage of the 5-stage pipeline. It sits directly downstream of the EX/MEM pipeline register and consumes its outputs (address, ALU result, PC values, register specifiers, opcode). It runs loads and stores against a data memory with a req/ack handshake, stalls the pipeline while an access is outstanding, and registers the write-back payload into the MEM/WB boundary.

## Interface
Parameters:
- TIMEOUT_CYC, 255: cycles in REQ without ack before abort; used only with MEM_TIMEOUT_EN; range 1..255.

Ports:
- clk  in  1  pipeline clock; all state changes on rising edge
- rst_n  in  1  asynchronous, active-low reset
- mem_addr_i  in  16  effective address from EX/MEM
- alu_data_i  in  16  ALU result; store data for SW
- pc_next_i  in  16  PC+2 of the instruction; PCS write-back value
- rd_i  in  4  destination register
- op_i  in  4  opcode
- flush_i  in  1  kill the current instruction (taken branch)
- dmem_req  out  1  registered access request
- dmem_we  out  1  1 = store; valid while dmem_req
- dmem_addr  out  16  registered address
- dmem_wdata  out  16  registered store data
- dmem_rdata  in  16  load data; valid with dmem_ack
- dmem_ack  in  1  one-cycle completion pulse
- stall_o  out  1  hold upstream stages; EX/MEM write enable = ~stall_o
- wb_data_o  out  16  registered write-back data
- wb_rd_o  out  4  registered destination
- wb_en_o  out  1  registered register-file write enable
- hlt_o  out  1  registered halt (op 1111 retired)
- err_o  out  1  sticky access-timeout flag

## Operation
- Opcode classes:
  - ALU: 0000–0111, LHB 1010, LLB 1011; wb_data = alu_data_i, wb_en = 1.
  - LW 1000: wb_data = dmem_rdata, wb_en = 1.
  - SW 1001: wb_en = 0.
  - PCS 1110: wb_data = pc_next_i, wb_en = 1.
  - B 1100, BR 1101: wb_en = 0.
  - HLT 1111: wb_en = 0, hlt = 1.
- wb_en is forced to 0 whenever rd_i == 0.
- FSM states:
  - IDLE: on LW/SW with flush_i = 0, go to REQ and load dmem_addr/dmem_wdata/dmem_we; stall_o = 1.
  - REQ: dmem_req = 1, stall_o = 1. When dmem_ack is sampled high, latch dmem_rdata into the load buffer and go to DONE.
  - DONE: dmem_req = 0, stall_o = 0. The WB registers capture at this edge; go to IDLE.
- Non-memory ops never leave IDLE. stall_o = 0 for them, and the WB registers capture every cycle.
- flush_i in IDLE: the WB registers load a bubble (wb_en = 0, hlt = 0).
- flush_i in REQ/DONE is ignored: the access completes and retires. The branch unit does not flush a stage that is stalled.
- dmem_ack outside REQ is ignored.
- stall_o is combinational: (op is LW/SW) and (state != DONE) and ~flush_i.

## Timing
- Reset values: state IDLE; dmem_req, dmem_we, stall_o, wb_en_o, hlt_o, err_o = 0; dmem_addr, dmem_wdata, wb_data_o, wb_rd_o = 0; load buffer = 0; timeout counter = 0.
- Reset is asynchronous. Asserting it mid-REQ drops dmem_req immediately and abandons the access.
- Non-memory op: 1-cycle latency from EX/MEM output to WB registers.
- LW/SW with ack on the first REQ cycle: 3 cycles in the stage (IDLE, REQ, DONE), with stall_o high for 2 cycles. Each additional wait cycle adds 1.
- Back-to-back memory ops: DONE → IDLE → REQ. There are no idle bubbles beyond the IDLE cycle itself.
- dmem_req remains high continuously from REQ entry until the cycle in which ack is sampled. It deasserts on the following edge.

## Configuration
- MEM_TIMEOUT_EN defined:
  - An 8-bit counter runs in REQ and clears on REQ entry.
  - After TIMEOUT_CYC cycles without ack, the FSM goes to DONE, err_o sets sticky until reset, and the instruction retires with wb_en = 0.
  - If ack arrives in the same cycle as the timeout, the ack takes priority.
- MEM_TIMEOUT_EN undefined: no counter is built, REQ waits indefinitely, and err_o is tied to 0.

## Test plan
- Reset, then ALU op 0000, rd = 3, alu_data = 0x1234 → next cycle wb_data = 0x1234, wb_rd = 3, wb_en = 1, stall_o never high.
- LW, addr 0x0040, ack 2 cycles after req with rdata 0xBEEF → stall_o high 3 cycles; wb_data = 0xBEEF, wb_en = 1 after the DONE edge.
- SW, addr 0x0010, data 0x00AA, immediately followed by LW 0x0010 → dmem_we = 1 then 0; req deasserts between accesses; second access returns memory model value 0x00AA.
- PCS with pc_next = 0x0102, rd = 0 → wb_en = 0. HLT → hlt_o = 1 one cycle later. flush_i with ALU op → bubble.
- rst_n pulled low mid-REQ → dmem_req and stall_o go 0 asynchronously; after release the state is IDLE and a stray ack is ignored.
- MEM_TIMEOUT_EN, TIMEOUT_CYC = 4, no ack → after 4 REQ cycles err_o = 1, wb_en = 0, pipeline resumes. Rerun with ack on cycle 4 → err_o stays 0.
